// File: rtl/fetch_engine_if.sv
// ---------------------------------------------------------------------------
// fetch_engine_if
// Bundles the request, memory-read and result signals of fetch_engine.
//
// Ports / signals:
//   start, base_addr, burst_len, hold  burst request side (driven by master)
//   read_bus                           per-channel memory read data (master)
//   read_en, read_addr                 memory read strobe and addresses (slave)
//   out_data, out_valid, out_index     extracted result beats (slave)
//   busy, done                         engine status (slave)
//
// Modports:
//   master  the controlling side (requester plus memory)
//   slave   the fetch engine itself
// ---------------------------------------------------------------------------
interface fetch_engine_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 128,
   parameter int OUT_W  = 15,
   parameter int LEN_W  = 3
) ();

   logic                      start;
   logic [NUM_CH*ADDR_W-1:0]  base_addr;
   logic [LEN_W-1:0]          burst_len;
   logic                      hold;
   logic [NUM_CH*BUS_W-1:0]   read_bus;

   logic                      read_en;
   logic [NUM_CH*ADDR_W-1:0]  read_addr;
   logic [NUM_CH*OUT_W-1:0]   out_data;
   logic                      out_valid;
   logic [LEN_W-1:0]          out_index;
   logic                      busy;
   logic                      done;

   modport master (
      output start, base_addr, burst_len, hold, read_bus,
      input  read_en, read_addr, out_data, out_valid, out_index, busy, done
   );

   modport slave (
      input  start, base_addr, burst_len, hold, read_bus,
      output read_en, read_addr, out_data, out_valid, out_index, busy, done
   );

endinterface

// File: rtl/fetch_engine.sv
// ---------------------------------------------------------------------------
// fetch_engine
// Multi-channel burst reader. A start request loads a base address per
// channel and a burst length; the engine then issues one common read strobe
// per cycle (unless held), stepping every channel address by STRIDE. Read
// data returns RD_LAT cycles later and the low OUT_W bits of each channel are
// registered onto out_data together with the beat number.
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous active-high reset
//   bus    fetch_engine_if.slave (request, memory read and result signals)
// ---------------------------------------------------------------------------
module fetch_engine #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 128,
   parameter int OUT_W  = 15,
   parameter int STRIDE = 2,
   parameter int LEN_W  = 3,
   parameter int RD_LAT = 1
) (
   input logic           clock,
   input logic           reset,
   fetch_engine_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t                    state;
   state_t                    state_next;

   logic [LEN_W-1:0]          len;
   logic [LEN_W-1:0]          issue_idx;
   logic [NUM_CH*ADDR_W-1:0]  addr_q;

   // valid/index shift pipeline tracking reads in flight to the memory
   logic [RD_LAT-1:0]         vpipe;
   logic [LEN_W-1:0]          ipipe [RD_LAT];

   logic [NUM_CH*OUT_W-1:0]   data_q;
   logic                      valid_q;
   logic [LEN_W-1:0]          index_q;

   logic                      issue_fire;
   logic                      last_issue;
   logic                      load_burst;
   logic                      unused_read_bus;

   // Only the low OUT_W bits of each channel are consumed.
   assign unused_read_bus = ^bus.read_bus;

   always_comb begin
      issue_fire = (state == ISSUE) && !bus.hold;
      last_issue = issue_fire && (issue_idx == (len - LEN_W'(1)));
      load_burst = (state == IDLE) && bus.start && (bus.burst_len != '0);
   end

   // Next-state logic. DRAIN waits until the final beat is on out_valid with
   // nothing left in the read pipeline, so DONE lands the cycle after it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.burst_len != '0) state_next = ISSUE;
               else                     state_next = DONE;
            end
         end
         ISSUE: begin
            if (last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            if (valid_q && (vpipe == '0)) state_next = DONE;
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Issue side: burst load, address stepping (wraps naturally at 2^ADDR_W)
   // and the issue index. hold simply suppresses issue_fire.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         len       <= '0;
         issue_idx <= '0;
      end else if (load_burst) begin
         addr_q    <= bus.base_addr;
         len       <= bus.burst_len;
         issue_idx <= '0;
      end else if (issue_fire) begin
         for (int c = 0; c < NUM_CH; c++) begin
            addr_q[c*ADDR_W +: ADDR_W] <= addr_q[c*ADDR_W +: ADDR_W] + ADDR_W'(STRIDE);
         end
         issue_idx <= issue_idx + LEN_W'(1);
      end
   end

   // Return side: the pipeline tail marks the cycle where read_bus holds the
   // data of a read issued RD_LAT cycles earlier; capture it then so the
   // result appears RD_LAT+1 cycles after the strobe. out_data holds between
   // beats.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vpipe   <= '0;
         for (int k = 0; k < RD_LAT; k++) ipipe[k] <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         index_q <= '0;
      end else begin
         vpipe[0] <= issue_fire;
         ipipe[0] <= issue_idx;
         for (int k = 1; k < RD_LAT; k++) begin
            vpipe[k] <= vpipe[k-1];
            ipipe[k] <= ipipe[k-1];
         end
         valid_q <= vpipe[RD_LAT-1];
         if (vpipe[RD_LAT-1]) begin
            index_q <= ipipe[RD_LAT-1];
            for (int c = 0; c < NUM_CH; c++) begin
               data_q[c*OUT_W +: OUT_W] <= bus.read_bus[c*BUS_W +: OUT_W];
            end
         end
      end
   end

   always_comb begin
      bus.read_en   = issue_fire;
      bus.read_addr = addr_q;
      bus.out_data  = data_q;
      bus.out_valid = valid_q;
      bus.out_index = index_q;
      bus.busy      = (state != IDLE);
      bus.done      = (state == DONE);
   end

endmodule

// File: tb/tb_fetch_engine.sv
// ---------------------------------------------------------------------------
// tb_fetch_engine
// Directed bench for fetch_engine. dut0 uses default parameters; dut1 uses
// NUM_CH=4, RD_LAT=3, STRIDE=4. Each DUT is fed by a small memory model whose
// data word is a fixed function of the address that was strobed.
// ---------------------------------------------------------------------------
module tb_fetch_engine;

   logic clock;
   logic reset;

   int tests_run    = 0;
   int tests_failed = 0;

   fetch_engine_if #(.NUM_CH(2), .ADDR_W(16), .BUS_W(128), .OUT_W(15), .LEN_W(3)) if0 ();
   fetch_engine_if #(.NUM_CH(4), .ADDR_W(16), .BUS_W(128), .OUT_W(15), .LEN_W(3)) if1 ();

   fetch_engine #(.NUM_CH(2), .ADDR_W(16), .BUS_W(128), .OUT_W(15),
                  .STRIDE(2), .LEN_W(3), .RD_LAT(1)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (if0)
   );

   fetch_engine #(.NUM_CH(4), .ADDR_W(16), .BUS_W(128), .OUT_W(15),
                  .STRIDE(4), .LEN_W(3), .RD_LAT(3)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (if1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory content: low 15 bits depend on channel and address, upper bits
   // are all ones so a wrong extraction window is visible.
   function automatic logic [14:0] mem_word(input int ch, input logic [15:0] a);
      logic [15:0] t;
      t = (a * 16'd7) ^ (16'h1357 + 16'(ch) * 16'h0A0B);
      return t[14:0];
   endfunction

   // Memory for dut0: one cycle latency.
   logic [31:0] m0_addr;
   always @(posedge clock) if (if0.read_en) m0_addr <= if0.read_addr;
   always_comb begin
      for (int c = 0; c < 2; c++)
         if0.read_bus[c*128 +: 128] = {{113{1'b1}}, mem_word(c, m0_addr[c*16 +: 16])};
   end

   // Memory for dut1: three cycle latency.
   logic [63:0] m1_a0, m1_a1, m1_a2;
   always @(posedge clock) begin
      m1_a0 <= if1.read_addr;
      m1_a1 <= m1_a0;
      m1_a2 <= m1_a1;
   end
   always_comb begin
      for (int c = 0; c < 4; c++)
         if1.read_bus[c*128 +: 128] = {{113{1'b1}}, mem_word(c, m1_a2[c*16 +: 16])};
   end

   // Per-burst record of dut0 activity, indexed by cycle after the start edge.
   logic [15:0] a0_q[$];
   logic [15:0] a1_q[$];
   logic [2:0]  bidx_q[$];
   logic [29:0] bdat_q[$];
   int          bcyc_q[$];
   logic        re_log[$];
   logic        busy_log[$];
   int          done_cyc;
   int          done_cnt;
   logic        timed_out;
   logic [29:0] done_data;

   // Steps dut0 cycle by cycle after a start has been driven, applying hold
   // per cycle from hold_mask and an optional second start at restart_cyc.
   task automatic applyStimulus(input int max_cyc, input logic [31:0] hold_mask,
                                input int restart_cyc);
      a0_q.delete(); a1_q.delete(); bidx_q.delete(); bdat_q.delete(); bcyc_q.delete();
      re_log.delete(); busy_log.delete();
      re_log.push_back(1'b0);
      busy_log.push_back(1'b0);
      done_cyc  = -1;
      done_cnt  = 0;
      timed_out = 1'b1;
      done_data = '0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clock);
         if0.start = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin
            if0.base_addr = 32'h7000_7000;
            if0.burst_len = 3'd5;
         end
         if0.hold = (cyc < 32) ? hold_mask[cyc] : 1'b0;
         #1;
         re_log.push_back(if0.read_en);
         busy_log.push_back(if0.busy);
         if (if0.read_en) begin
            a0_q.push_back(if0.read_addr[15:0]);
            a1_q.push_back(if0.read_addr[31:16]);
         end
         if (if0.out_valid) begin
            bidx_q.push_back(if0.out_index);
            bdat_q.push_back(if0.out_data);
            bcyc_q.push_back(cyc);
         end
         if (if0.done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc  = cyc;
               done_data = if0.out_data;
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            timed_out = 1'b0;
            break;
         end
      end
      if0.start = 1'b0;
      if0.hold  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if0.start = 1'b0; if0.hold = 1'b0; if0.base_addr = '0; if0.burst_len = '0;
      if1.start = 1'b0; if1.hold = 1'b0; if1.base_addr = '0; if1.burst_len = '0;
      repeat (2) @(negedge clock);
      #1;
      tests_run++; if (if0.read_en !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_read_en: got %b expected 0", if0.read_en); end
      tests_run++; if (if0.read_addr !== '0)   begin tests_failed++; $display("[TB] FAIL reset_read_addr: got %h expected 0", if0.read_addr); end
      tests_run++; if (if0.out_data !== '0)    begin tests_failed++; $display("[TB] FAIL reset_out_data: got %h expected 0", if0.out_data); end
      tests_run++; if (if0.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b expected 0", if0.out_valid); end
      tests_run++; if (if0.out_index !== '0)   begin tests_failed++; $display("[TB] FAIL reset_out_index: got %h expected 0", if0.out_index); end
      tests_run++; if (if0.busy !== 1'b0)      begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", if0.busy); end
      tests_run++; if (if0.done !== 1'b0)      begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", if0.done); end
      tests_run++; if (if1.busy !== 1'b0 || if1.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_dut1: busy %b valid %b expected 0 0", if1.busy, if1.out_valid); end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_basic_burst();
      logic [29:0] exp_d;
      @(negedge clock);
      if0.base_addr = {16'h0100, 16'h0010}; if0.burst_len = 3'd4; if0.start = 1'b1; if0.hold = 1'b0;
      applyStimulus(40, 32'h0, -1);
      tests_run++; if (timed_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_timeout: done not seen, got timeout %b expected 0", timed_out); end
      tests_run++; if (a0_q.size() !== 4) begin tests_failed++; $display("[TB] FAIL basic_reads: got %0d expected 4", a0_q.size()); end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (a0_q[i] !== 16'h0010 + 16'(2*i) || a1_q[i] !== 16'h0100 + 16'(2*i)) begin
            tests_failed++; $display("[TB] FAIL basic_addr%0d: got %h/%h expected %h/%h", i, a0_q[i], a1_q[i], 16'h0010 + 16'(2*i), 16'h0100 + 16'(2*i));
         end
      end
      for (int c = 1; c <= 5; c++) begin
         tests_run++; if (re_log[c] !== (c <= 4)) begin tests_failed++; $display("[TB] FAIL basic_read_en_c%0d: got %b expected %b", c, re_log[c], (c <= 4)); end
      end
      tests_run++; if (bidx_q.size() !== 4) begin tests_failed++; $display("[TB] FAIL basic_beats: got %0d expected 4", bidx_q.size()); end
      for (int i = 0; i < 4; i++) begin
         exp_d = {mem_word(1, 16'h0100 + 16'(2*i)), mem_word(0, 16'h0010 + 16'(2*i))};
         tests_run++;
         if (bidx_q[i] !== 3'(i) || bcyc_q[i] !== 3 + i || bdat_q[i] !== exp_d) begin
            tests_failed++; $display("[TB] FAIL basic_beat%0d: got idx %0d cyc %0d data %h expected idx %0d cyc %0d data %h", i, bidx_q[i], bcyc_q[i], bdat_q[i], i, 3 + i, exp_d);
         end
      end
      exp_d = {mem_word(1, 16'h0106), mem_word(0, 16'h0016)};
      tests_run++; if (done_cyc !== 7) begin tests_failed++; $display("[TB] FAIL basic_done_cycle: got %0d expected 7", done_cyc); end
      tests_run++; if (done_data !== exp_d) begin tests_failed++; $display("[TB] FAIL basic_data_hold: got %h expected %h", done_data, exp_d); end
      tests_run++; if (busy_log[7] !== 1'b1 || busy_log[8] !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_tail: got %b%b expected 10", busy_log[7], busy_log[8]); end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_a [3];
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'h0000; exp_a[2] = 16'h0002;
      @(negedge clock);
      if0.base_addr = {16'h1234, 16'hFFFE}; if0.burst_len = 3'd3; if0.start = 1'b1;
      applyStimulus(40, 32'h0, -1);
      tests_run++; if (a0_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL wrap_reads: got %0d expected 3", a0_q.size()); end
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (a0_q[i] !== exp_a[i] || a1_q[i] !== 16'h1234 + 16'(2*i)) begin
            tests_failed++; $display("[TB] FAIL wrap_addr%0d: got %h/%h expected %h/%h", i, a0_q[i], a1_q[i], exp_a[i], 16'h1234 + 16'(2*i));
         end
         tests_run++;
         if (bdat_q[i] !== {mem_word(1, 16'h1234 + 16'(2*i)), mem_word(0, exp_a[i])}) begin
            tests_failed++; $display("[TB] FAIL wrap_data%0d: got %h expected %h", i, bdat_q[i], {mem_word(1, 16'h1234 + 16'(2*i)), mem_word(0, exp_a[i])});
         end
      end
      tests_run++; if (done_cyc !== 6) begin tests_failed++; $display("[TB] FAIL wrap_done_cycle: got %0d expected 6", done_cyc); end
   endtask

   task automatic test_zero_len();
      @(negedge clock);
      if0.base_addr = {16'h0AAA, 16'h0555}; if0.burst_len = 3'd0; if0.start = 1'b1;
      applyStimulus(20, 32'h0, -1);
      tests_run++; if (a0_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL zero_read_en: got %0d reads expected 0", a0_q.size()); end
      tests_run++; if (bidx_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL zero_beats: got %0d expected 0", bidx_q.size()); end
      tests_run++; if (done_cyc !== 1) begin tests_failed++; $display("[TB] FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
      tests_run++; if (busy_log[1] !== 1'b1 || busy_log[2] !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_busy: got %b%b expected 10", busy_log[1], busy_log[2]); end
   endtask

   task automatic test_hold();
      logic exp_re [9];
      int   exp_cyc [5];
      exp_re = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      exp_cyc = '{3, 6, 7, 8, 9};
      @(negedge clock);
      if0.base_addr = {16'h0200, 16'h0040}; if0.burst_len = 3'd5; if0.start = 1'b1;
      applyStimulus(40, 32'h0000_000C, -1);
      for (int c = 1; c <= 8; c++) begin
         tests_run++; if (re_log[c] !== exp_re[c]) begin tests_failed++; $display("[TB] FAIL hold_read_en_c%0d: got %b expected %b", c, re_log[c], exp_re[c]); end
      end
      tests_run++; if (bidx_q.size() !== 5) begin tests_failed++; $display("[TB] FAIL hold_beats: got %0d expected 5", bidx_q.size()); end
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (bidx_q[i] !== 3'(i) || bcyc_q[i] !== exp_cyc[i] || a0_q[i] !== 16'h0040 + 16'(2*i)
             || bdat_q[i] !== {mem_word(1, 16'h0200 + 16'(2*i)), mem_word(0, 16'h0040 + 16'(2*i))}) begin
            tests_failed++; $display("[TB] FAIL hold_beat%0d: got idx %0d cyc %0d addr %h data %h expected idx %0d cyc %0d addr %h", i, bidx_q[i], bcyc_q[i], a0_q[i], bdat_q[i], i, exp_cyc[i], 16'h0040 + 16'(2*i));
         end
      end
      tests_run++; if (done_cyc !== 10 || done_cnt !== 1) begin tests_failed++; $display("[TB] FAIL hold_done: got cyc %0d cnt %0d expected cyc 10 cnt 1", done_cyc, done_cnt); end
   endtask

   task automatic test_start_while_busy();
      @(negedge clock);
      if0.base_addr = {16'h0300, 16'h0080}; if0.burst_len = 3'd3; if0.start = 1'b1;
      applyStimulus(40, 32'h0, 2);
      tests_run++; if (a0_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL busy_start_reads: got %0d expected 3", a0_q.size()); end
      tests_run++; if (bidx_q.size() !== 3) begin tests_failed++; $display("[TB] FAIL busy_start_beats: got %0d expected 3", bidx_q.size()); end
      tests_run++; if (a0_q[2] !== 16'h0084) begin tests_failed++; $display("[TB] FAIL busy_start_addr: got %h expected 0084", a0_q[2]); end
      tests_run++; if (done_cyc !== 6 || done_cnt !== 1) begin tests_failed++; $display("[TB] FAIL busy_start_done: got cyc %0d cnt %0d expected cyc 6 cnt 1", done_cyc, done_cnt); end
      tests_run++; if (busy_log[7] !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_start_idle: got busy %b expected 0", busy_log[7]); end
   endtask

   task automatic test_reset_mid();
      int stray;
      @(negedge clock);
      if0.base_addr = {16'h0500, 16'h0020}; if0.burst_len = 3'd6; if0.start = 1'b1;
      @(negedge clock);
      if0.start = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      tests_run++; if (if0.read_addr !== {16'h0504, 16'h0024}) begin tests_failed++; $display("[TB] FAIL midreset_pre_addr: got %h expected 05040024", if0.read_addr); end
      #1;
      reset = 1'b1;
      #1;
      tests_run++;
      if (if0.read_en !== 1'b0 || if0.read_addr !== '0 || if0.out_data !== '0 || if0.out_valid !== 1'b0
          || if0.out_index !== '0 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL midreset_outputs: got re %b addr %h data %h valid %b idx %0d busy %b done %b expected all 0", if0.read_en, if0.read_addr, if0.out_data, if0.out_valid, if0.out_index, if0.busy, if0.done);
      end
      @(negedge clock);
      reset = 1'b0;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock); #1;
         if (if0.out_valid || if0.done || if0.read_en || if0.busy) stray++;
      end
      tests_run++; if (stray !== 0) begin tests_failed++; $display("[TB] FAIL midreset_stray: got %0d active cycles expected 0", stray); end
      @(negedge clock);
      if0.base_addr = {16'h0900, 16'h0060}; if0.burst_len = 3'd2; if0.start = 1'b1;
      applyStimulus(40, 32'h0, -1);
      tests_run++; if (bidx_q.size() !== 2 || done_cyc !== 5) begin tests_failed++; $display("[TB] FAIL midreset_rerun: got %0d beats done %0d expected 2 beats done 5", bidx_q.size(), done_cyc); end
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (a0_q[i] !== 16'h0060 + 16'(2*i) || a1_q[i] !== 16'h0900 + 16'(2*i) || bidx_q[i] !== 3'(i)
             || bdat_q[i] !== {mem_word(1, 16'h0900 + 16'(2*i)), mem_word(0, 16'h0060 + 16'(2*i))}) begin
            tests_failed++; $display("[TB] FAIL midreset_beat%0d: got addr %h/%h idx %0d data %h expected addr %h/%h idx %0d", i, a0_q[i], a1_q[i], bidx_q[i], bdat_q[i], 16'h0060 + 16'(2*i), 16'h0900 + 16'(2*i), i);
         end
      end
   endtask

   task automatic test_param_sweep();
      int          nread;
      int          nbeat;
      int          dcyc;
      logic [15:0] exp_a;
      nread = 0; nbeat = 0; dcyc = -1;
      @(negedge clock);
      if1.base_addr = {16'h0400, 16'h0300, 16'h0200, 16'h0100}; if1.burst_len = 3'd3;
      if1.start = 1'b1; if1.hold = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clock);
         if1.start = 1'b0;
         #1;
         if (if1.read_en) begin
            tests_run++; if (cyc !== nread + 1) begin tests_failed++; $display("[TB] FAIL sweep_read_cycle%0d: got %0d expected %0d", nread, cyc, nread + 1); end
            for (int c = 0; c < 4; c++) begin
               exp_a = 16'(16'h0100 * (c + 1)) + 16'(4 * nread);
               tests_run++; if (if1.read_addr[c*16 +: 16] !== exp_a) begin tests_failed++; $display("[TB] FAIL sweep_addr_r%0d_ch%0d: got %h expected %h", nread, c, if1.read_addr[c*16 +: 16], exp_a); end
            end
            nread++;
         end
         if (if1.out_valid) begin
            tests_run++; if (cyc !== nbeat + 5 || if1.out_index !== 3'(nbeat)) begin tests_failed++; $display("[TB] FAIL sweep_beat%0d: got cyc %0d idx %0d expected cyc %0d idx %0d", nbeat, cyc, if1.out_index, nbeat + 5, nbeat); end
            for (int c = 0; c < 4; c++) begin
               exp_a = 16'(16'h0100 * (c + 1)) + 16'(4 * nbeat);
               tests_run++; if (if1.out_data[c*15 +: 15] !== mem_word(c, exp_a)) begin tests_failed++; $display("[TB] FAIL sweep_data_b%0d_ch%0d: got %h expected %h", nbeat, c, if1.out_data[c*15 +: 15], mem_word(c, exp_a)); end
            end
            nbeat++;
         end
         if (if1.done) begin
            dcyc = cyc;
            break;
         end
      end
      tests_run++; if (nread !== 3 || nbeat !== 3) begin tests_failed++; $display("[TB] FAIL sweep_counts: got %0d reads %0d beats expected 3 3", nread, nbeat); end
      tests_run++; if (dcyc !== 8) begin tests_failed++; $display("[TB] FAIL sweep_done_cycle: got %0d expected 8", dcyc); end
   endtask

   initial begin
      test_reset();
      test_basic_burst();
      test_wrap();
      test_zero_len();
      test_hold();
      test_start_while_busy();
      test_reset_mid();
      test_param_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fetch_engine.md
FETCH_ENGINE -- requirements
Module: fetch_engine

Parameters
REQ-001 NUM_CH, default 2: number of independent read channels.
REQ-002 ADDR_W, default 16: read address width per channel.
REQ-003 BUS_W, default 128: read data bus width per channel.
REQ-004 OUT_W, default 15: extracted output field width per channel; OUT_W <= BUS_W.
REQ-005 STRIDE, default 2: address increment per read.
REQ-006 LEN_W, default 3: burst-length width; maximum burst is 2^LEN_W-1 reads.
REQ-007 RD_LAT, default 1: memory read latency in cycles, >= 1.

Interface
REQ-008 clock  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 start  in  1  burst request; sampled only in IDLE.
REQ-011 base_addr  in  NUM_CH*ADDR_W  per-channel start address; channel c occupies bits [c*ADDR_W +: ADDR_W].
REQ-012 burst_len  in  LEN_W  number of reads per channel, sampled with start.
REQ-013 hold  in  1  issue stall.
REQ-014 read_bus  in  NUM_CH*BUS_W  per-channel memory read data.
REQ-015 read_en  out  1  read strobe, common to all channels.
REQ-016 read_addr  out  NUM_CH*ADDR_W  registered per-channel read address.
REQ-017 out_data  out  NUM_CH*OUT_W  registered read_bus[c*BUS_W +: OUT_W] per channel.
REQ-018 out_valid  out  1  out_data and out_index are valid this cycle.
REQ-019 out_index  out  LEN_W  beat number 0..burst_len-1 of the current out_data.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.
REQ-021 done  out  1  one-cycle burst-complete pulse.

Function
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-023 In IDLE, start=1 with burst_len!=0 SHALL load read_addr<=base_addr, load len<=burst_len, clear the issue index, and go to ISSUE.
REQ-024 In IDLE, start=1 with burst_len==0 SHALL go directly to DONE without asserting read_en.
REQ-025 read_en SHALL equal (state==ISSUE && !hold), combinationally.
REQ-026 On each read_en cycle, each channel's read_addr SHALL advance by STRIDE, modulo 2^ADDR_W (wrap-around, no saturation), and the issue index SHALL increment.
REQ-027 The read_en cycle with issue index == len-1 SHALL move the FSM to DRAIN; read_addr still advances on that cycle.
REQ-028 hold=1 in ISSUE SHALL freeze read_addr and the issue index; reads already in flight SHALL still complete.
REQ-029 read_bus SHALL be sampled RD_LAT cycles after the read_en cycle, into out_data.
REQ-030 out_valid SHALL assert exactly RD_LAT+1 cycles after each read_en cycle, via a valid/index shift pipeline.
REQ-031 out_index SHALL carry the issue index of the matching read.
REQ-032 out_data SHALL hold its value when out_valid=0.
REQ-033 DRAIN SHALL go to DONE on the cycle after the last out_valid; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-034 done SHALL equal (state==DONE).
REQ-035 start outside IDLE SHALL be ignored; there is no queueing.
REQ-036 Every burst SHALL produce exactly burst_len out_valid beats, regardless of the hold pattern.

Reset
REQ-037 reset=1 SHALL immediately force IDLE, clear the pipeline, and drive read_addr, out_data, out_index, the issue index and len to 0; out_valid, read_en, busy and done SHALL be 0.
REQ-038 Reset mid-burst SHALL abort the burst; no out_valid or done SHALL appear for the aborted burst after reset deasserts.

Verification
REQ-039 Basic burst, defaults: base ch0=0x0010, ch1=0x0100, burst_len=4 -> read_addr ch0 0x10,0x12,0x14,0x16 and ch1 0x100..0x106 on 4 consecutive read_en cycles; out_valid for 4 cycles starting 2 cycles after the first read_en; out_index 0,1,2,3; out_data = read_bus[14:0] per channel; done one cycle after the last beat.
REQ-040 Wrap-around: base ch0=0xFFFE, burst_len=3 -> read_addr 0xFFFE, 0x0000, 0x0002.
REQ-041 Zero length: start with burst_len=0 -> no read_en; done=1 on the cycle after start; busy=1 for that one cycle only.
REQ-042 Hold: burst_len=5 with hold=1 on the 2nd and 3rd ISSUE cycles -> read_en pattern 1,0,0,1,1,1,1; exactly 5 beats; out_index 0..4 in order.
REQ-043 Reset mid-burst: reset asserted after 2 of 6 reads -> all outputs 0 asynchronously; FSM in IDLE; a new start then runs a clean burst from the new base_addr.
REQ-044 Start while busy: second start pulse during ISSUE -> ignored; beat count equals the first burst_len.
REQ-045 Parameter sweep: NUM_CH=4, RD_LAT=3, STRIDE=4 -> out_valid 4 cycles after each read_en; all channels step by 4.
